// File: rtl/rtc_read_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// rtc_read_sequencer_pkg
// Shared state encoding, RTC register map and default multiplexed-bus timing.
// Revision: 1.0
// ============================================================================
package rtc_read_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ADDR      = 3'd2,
    ST_TURN      = 3'd3,
    ST_READ      = 3'd4,
    ST_REC       = 3'd5
  } state_t;

  localparam logic [7:0] c_addr_seg  = 8'h21;
  localparam logic [7:0] c_addr_min  = 8'h22;
  localparam logic [7:0] c_addr_hora = 8'h23;

  // Bus timing shared with the initialization stage so both masters agree.
  localparam int c_t_addr = 4;
  localparam int c_t_turn = 2;
  localparam int c_t_rd   = 6;
  localparam int c_t_rec  = 4;
  localparam int c_period = 50000;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [7:0] reg_addr(input logic [1:0] idx, input logic [7:0] a0,
                                          input logic [7:0] a1, input logic [7:0] a2);
    case (idx)
      2'd0:    return a0;
      2'd1:    return a1;
      default: return a2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_phase_timer.sv
`default_nettype none
// ============================================================================
// rtc_phase_timer
// Loadable free-running down-counter with a terminal-count (zero) flag.
// Revision: 1.0
// ============================================================================
module rtc_phase_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// rtc_read_sequencer
// Waits for RTC init, then periodically reads seconds/minutes/hours over the bus.
// Revision: 1.0
// ============================================================================
module rtc_read_sequencer
  import rtc_read_sequencer_pkg::*;
#(
  parameter int         T_ADDR    = c_t_addr,
  parameter int         T_TURN    = c_t_turn,
  parameter int         T_RD      = c_t_rd,
  parameter int         T_REC     = c_t_rec,
  parameter int         PERIOD    = c_period,
  parameter logic [7:0] ADDR_SEG  = c_addr_seg,
  parameter logic [7:0] ADDR_MIN  = c_addr_min,
  parameter logic [7:0] ADDR_HORA = c_addr_hora
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_done,
  output logic       init_en,
  output logic       bus_owner,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic       data_valid
);

  localparam int c_ph_w  = $clog2(max4(T_ADDR, T_TURN, T_RD, T_REC) + 1);
  localparam int c_per_w = $clog2(PERIOD);

  localparam logic [c_ph_w-1:0]  c_ld_addr   = c_ph_w'(T_ADDR - 1);
  localparam logic [c_ph_w-1:0]  c_ld_turn   = c_ph_w'(T_TURN - 1);
  localparam logic [c_ph_w-1:0]  c_ld_rd     = c_ph_w'(T_RD - 1);
  localparam logic [c_ph_w-1:0]  c_ld_rec    = c_ph_w'(T_REC - 1);
  localparam logic [c_per_w-1:0] c_ld_period = c_per_w'(PERIOD - 1);

  state_t              r_state;
  logic [1:0]          r_idx;
  logic                r_first;
  logic                w_ph_tc;
  logic                w_per_tc;
  logic                w_start;
  logic                w_ph_load;
  logic [c_ph_w-1:0]   w_ph_val;

  // A triple starts immediately after init, then every PERIOD cycles.
  assign w_start   = (r_state == ST_IDLE) && (r_first || w_per_tc);
  assign w_ph_load = w_start ||
                     (w_ph_tc && (r_state != ST_INIT_WAIT) && (r_state != ST_IDLE));

  // Load value is the duration of the phase being entered.
  always_comb begin
    w_ph_val = c_ld_addr;
    case (r_state)
      ST_ADDR: w_ph_val = c_ld_turn;
      ST_TURN: w_ph_val = c_ld_rd;
      ST_READ: w_ph_val = c_ld_rec;
      default: w_ph_val = c_ld_addr;
    endcase
  end

  rtc_phase_timer #(.WIDTH(c_ph_w)) u_phase_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_ph_load),
    .i_load_val (w_ph_val),
    .o_tc       (w_ph_tc)
  );

  rtc_phase_timer #(.WIDTH(c_per_w)) u_period_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_start),
    .i_load_val (c_ld_period),
    .o_tc       (w_per_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_INIT_WAIT;
      r_idx      <= 2'd0;
      r_first    <= 1'b0;
      init_en    <= 1'b0;
      bus_owner  <= 1'b0;
      ad_oe      <= 1'b0;
      ad_out     <= 8'h00;
      AD         <= 1'b1;
      CS         <= 1'b1;
      RD         <= 1'b1;
      WR         <= 1'b1;
      seg        <= 8'h00;
      min        <= 8'h00;
      hora       <= 8'h00;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      WR         <= 1'b1;
      case (r_state)
        ST_INIT_WAIT: begin
          if (init_done) begin
            init_en   <= 1'b0;
            bus_owner <= 1'b1;
            r_first   <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            init_en <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_start) begin
            r_first <= 1'b0;
            r_idx   <= 2'd0;
            CS      <= 1'b0;
            AD      <= 1'b0;
            ad_oe   <= 1'b1;
            ad_out  <= reg_addr(2'd0, ADDR_SEG, ADDR_MIN, ADDR_HORA);
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (w_ph_tc) begin
            AD      <= 1'b1;
            ad_oe   <= 1'b0;
            r_state <= ST_TURN;
          end
        end
        ST_TURN: begin
          if (w_ph_tc) begin
            RD      <= 1'b0;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_ph_tc) begin
            RD <= 1'b1;
            CS <= 1'b1;
            case (r_idx)
              2'd0:    seg  <= ad_in;
              2'd1:    min  <= ad_in;
              default: hora <= ad_in;
            endcase
            r_state <= ST_REC;
          end
        end
        ST_REC: begin
          if (w_ph_tc) begin
            if (r_idx == 2'd2) begin
              data_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              CS      <= 1'b0;
              AD      <= 1'b0;
              ad_oe   <= 1'b1;
              ad_out  <= reg_addr(r_idx + 2'd1, ADDR_SEG, ADDR_MIN, ADDR_HORA);
              r_state <= ST_ADDR;
            end
          end
        end
        default: r_state <= ST_INIT_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rtc_read_sequencer
// Randomized RTC bus model with a scoreboard of expected seconds/minutes/hours triples.
// Revision: 1.0
// ============================================================================
module tb_rtc_read_sequencer;

  localparam int c_tb_period = 200;
  localparam int c_t_addr    = 4;
  localparam int c_t_rd      = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       init_done = 1'b0;
  logic [7:0] ad_in = 8'h00;
  logic       init_en, bus_owner, ad_oe, AD, CS, RD, WR, data_valid;
  logic [7:0] ad_out, seg, min, hora;

  rtc_read_sequencer #(.PERIOD(c_tb_period)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_done  (init_done),
    .init_en    (init_en),
    .bus_owner  (bus_owner),
    .ad_in      (ad_in),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .AD         (AD),
    .CS         (CS),
    .RD         (RD),
    .WR         (WR),
    .seg        (seg),
    .min        (min),
    .hora       (hora),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mem [256];
  logic [23:0] exp_q [$];
  logic [23:0] sb_e;
  logic [7:0]  lat_addr = 8'h00;
  int          rd_cnt = 0;
  logic [7:0]  addr_tab [3] = '{8'h21, 8'h22, 8'h23};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_triple();
    exp_q.push_back({mem[8'h21], mem[8'h22], mem[8'h23]});
  endtask

  task automatic wait_dv(input int budget, input string what);
    int k;
    k = 0;
    @(negedge clk);
    while (!data_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!data_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_%s: no data_valid within %0d cycles, expected one", what, budget);
    end
  endtask

  // RTC model: latches the address, returns garbage until the final RD-low cycle.
  always @(posedge clk) begin
    #1;
    if (!AD && ad_oe) lat_addr = ad_out;
    if (!RD) rd_cnt = rd_cnt + 1;
    else     rd_cnt = 0;
    if (!RD && rd_cnt >= c_t_rd) ad_in = mem[lat_addr];
    else                         ad_in = mem[lat_addr] ^ 8'($urandom_range(1, 255));
  end

  int   cyc = 0, ad_run = 0, rd_run = 0, ad_seq = 0, dv_since = 0, dv_total = 0, last_start = -1;
  logic prev_dv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      ad_run = 0; rd_run = 0; ad_seq = 0; dv_since = 0; last_start = -1; prev_dv = 1'b0;
    end else begin
      chk("oe_with_rd_low", {31'b0, ad_oe & ~RD}, 0);
      chk("ad_low_without_cs", {31'b0, ~AD & CS}, 0);
      chk("wr_high", {31'b0, WR}, 1);
      if (!AD) begin
        if (ad_run == 0 && (ad_seq % 3) == 0) begin
          if (last_start >= 0) begin
            chk("period", cyc - last_start, c_tb_period);
            chk("dv_per_triple", dv_since, 1);
          end
          last_start = cyc;
          dv_since   = 0;
        end
        chk("ad_out_addr", {24'b0, ad_out}, {24'b0, addr_tab[ad_seq % 3]});
        ad_run++;
      end else if (ad_run != 0) begin
        chk("ad_low_len", ad_run, c_t_addr);
        ad_run = 0;
        ad_seq++;
      end
      if (!RD) rd_run++;
      else if (rd_run != 0) begin
        chk("rd_low_len", rd_run, c_t_rd);
        rd_run = 0;
      end
      if (data_valid) begin
        dv_since++;
        dv_total++;
        chk("dv_width", {31'b0, prev_dv}, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard: data_valid with empty queue, expected no pulse");
        end else begin
          sb_e = exp_q.pop_front();
          chk("seg", {24'b0, seg}, {24'b0, sb_e[23:16]});
          chk("min", {24'b0, min}, {24'b0, sb_e[15:8]});
          chk("hora", {24'b0, hora}, {24'b0, sb_e[7:0]});
        end
      end
      prev_dv = data_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected summary earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h21] = 8'h45; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;

    repeat (3) @(negedge clk);
    chk("rst_init_en", {31'b0, init_en}, 0);
    chk("rst_bus_owner", {31'b0, bus_owner}, 0);
    chk("rst_pins", {27'b0, CS, AD, RD, WR, ad_oe}, 32'b11110);
    chk("rst_ad_out", {24'b0, ad_out}, 0);
    chk("rst_regs", {8'b0, seg, min, hora}, 0);
    chk("rst_dv", {31'b0, data_valid}, 0);

    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("wait_init_en", {31'b0, init_en}, 1);
      chk("wait_bus_owner", {31'b0, bus_owner}, 0);
      chk("wait_pins", {27'b0, CS, AD, RD, WR, ad_oe}, 32'b11110);
    end

    push_triple();
    init_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("done_init_en", {31'b0, init_en}, 0);
    chk("done_bus_owner", {31'b0, bus_owner}, 1);

    for (int t = 0; t < 5; t++) begin
      wait_dv(c_tb_period + 50, "triple");
      repeat (5) @(negedge clk);
      if (t == 1) init_done = 1'b0;
      mem[8'h21] = (t == 0) ? 8'h59 : 8'($urandom);
      mem[8'h22] = 8'($urandom);
      mem[8'h23] = 8'($urandom);
      push_triple();
    end

    k = 0;
    while (!(!RD && lat_addr == 8'h22 && rd_cnt == 3) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_min_read: minutes read not reached, expected within 400 cycles");
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_pins", {28'b0, CS, RD, AD, ad_oe}, 32'b1110);
    chk("midrst_regs", {8'b0, seg, min, hora}, 0);
    chk("midrst_owner", {30'b0, init_en, bus_owner}, 0);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("restart_init_en", {31'b0, init_en}, 1);
    chk("restart_bus_owner", {31'b0, bus_owner}, 0);
    chk("restart_pins", {27'b0, CS, AD, RD, WR, ad_oe}, 32'b11110);

    push_triple();
    init_done = 1'b1;
    wait_dv(c_tb_period + 50, "restart");
    repeat (5) @(negedge clk);
    chk("dv_total", dv_total, 6);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rtc_read_sequencer.md
Name: rtc_read_sequencer

Overview:
- Master sequencer for the multiplexed-bus RTC, directly downstream of the initialization stage.
- After reset it enables the initializer, waits for its done flag, then takes bus ownership.
- It then periodically runs read cycles for seconds, minutes and hours.
- Read values are latched into output registers for the display/formatting stage, with a one-cycle valid pulse per completed triple.

Parameters:
- T_ADDR, 4: cycles address phase (AD low, address driven).
- T_TURN, 2: cycles bus turnaround (driver off, AD high) before RD.
- T_RD, 6: cycles RD low; data sampled on the last RD-low cycle.
- T_REC, 4: cycles recovery (CS, RD high) between transactions.
- PERIOD, 50000: cycles from the start of one read triple to the start of the next (must exceed 3*(T_ADDR+T_TURN+T_RD+T_REC)).
- ADDR_SEG, 8'h21: seconds register address.
- ADDR_MIN, 8'h22: minutes register address.
- ADDR_HORA, 8'h23: hours register address.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous active-high reset.
- init_done, input, 1: done flag from the initialization stage (its band output).
- init_en, output, 1: enable to the initialization stage.
- bus_owner, output, 1: 0 = initializer drives the RTC pins, 1 = this block drives them; selects the pin mux.
- ad_in, input, 8: RTC AD bus, input side.
- ad_out, output, 8: RTC AD bus, output side.
- ad_oe, output, 1: tristate enable for ad_out, 1 = drive.
- AD, output, 1: address strobe, active low.
- CS, output, 1: chip select, active low.
- RD, output, 1: read strobe, active low.
- WR, output, 1: write strobe, active low; held high (block never writes).
- seg, output, 8: last seconds value read.
- min, output, 8: last minutes value read.
- hora, output, 8: last hours value read.
- data_valid, output, 1: one-cycle pulse after hora updates.

Behaviour:
- Reset (asynchronous, immediate):
  - State INIT_WAIT; all phase, period and register-index counters 0.
  - init_en=0, bus_owner=0, ad_oe=0, ad_out=0.
  - AD=CS=RD=WR=1.
  - seg=min=hora=0, data_valid=0.
- INIT_WAIT: init_en=1, bus_owner=0. When init_done=1 is sampled: init_en=0 next cycle, go to IDLE. init_done is level; a glitch shorter than one cycle is not required to be caught.
- IDLE: bus_owner=1, CS=1, ad_oe=0. The period counter counts each cycle. At count PERIOD-1, or on the first entry after INIT_WAIT, clear the counter, set index=0, go to ADDR.
- ADDR (T_ADDR cycles):
  - CS=0, AD=0, ad_oe=1.
  - ad_out = ADDR_SEG, ADDR_MIN or ADDR_HORA for index 0, 1 or 2.
- TURN (T_TURN cycles): CS=0, AD=1, ad_oe=0.
- READ (T_RD cycles):
  - CS=0, RD=0, ad_oe=0.
  - On the last cycle, ad_in is captured into the register selected by index; the update is visible the next cycle.
- REC (T_REC cycles): CS=1, RD=1, ad_oe=0.
  - Index<2: index+1, go to ADDR.
  - Index=2: data_valid=1 for exactly one cycle (the first cycle of IDLE), go to IDLE.
- Period counter:
  - Runs continuously from the start of the triple, so triples start exactly PERIOD cycles apart.
  - Width is ceil(log2(PERIOD)); it wraps to 0 and never saturates.
- Phase counter:
  - Reloads on each state entry.
  - Each phase lasts exactly its parameter value; a parameter value of 0 is illegal.
- Bus safety:
  - ad_oe and RD=0 are never asserted in the same cycle.
  - AD=0 only while CS=0.
  - WR is constant 1 after reset.
- All outputs are registered; no combinational path from ad_in or init_done to any output.
- Reset mid-transaction: pins release immediately (CS=RD=AD=1, ad_oe=0). Partially read values are discarded, and the sequence restarts in INIT_WAIT.
- init_done dropping after INIT_WAIT has no effect. Re-initialization only happens via reset.

Decomposition:
- Shared package holds:
  - state encoding (INIT_WAIT, IDLE, ADDR, TURN, READ, REC);
  - the RTC register address constants;
  - the default timing constants, also used by the initialization stage so both masters meet the same RTC timing.
- One natural sub-module, rtc_phase_timer: a loadable down-counter with a terminal-count flag. It is instantiated twice, once for the phase timing and once for the period.

Test Plan:
- Reset release with init_done=0 for 100 cycles -> init_en=1, bus_owner=0, CS=AD=RD=WR=1, no bus activity; then init_done=1 -> init_en=0 and bus_owner=1 within 2 cycles.
- First triple with RTC model returning 8'h45, 8'h30, 8'h12 for 0x21, 0x22, 0x23:
  - ad_out shows 0x21, 0x22, 0x23 during AD low, each for exactly 4 cycles;
  - RD low exactly 6 cycles per transaction;
  - seg=8'h45, min=8'h30, hora=8'h12;
  - single data_valid pulse.
- Periodicity with PERIOD=200: the start of each ADDR for index 0 is exactly 200 cycles apart over 5 triples; data_valid occurs once per triple.
- Bus-contention checker over the full run -> never ad_oe=1 while RD=0; AD=0 never while CS=1; WR always 1.
- Asynchronous reset asserted mid-READ of minutes -> same cycle: CS=RD=1, ad_oe=0; seg, min, hora, init_en, bus_owner return to reset values; the sequence restarts from INIT_WAIT.
- RTC model changes ad_in during the first 5 RD-low cycles and settles to 8'h59 on the last -> captured seg=8'h59.
